// File: rtl/mmp_cmd_pkg.sv
// Shared command-stream definitions for the sound-chip sequencer path:
// opcodes, 24-bit command field layout, FSM states and the default frame period.
package mmp_cmd_pkg;

   localparam int unsigned FRAME_TICKS_DEFAULT = 32'd297619;

   localparam int CMD_W  = 24;
   localparam int OPC_HI = 23;
   localparam int OPC_LO = 19;
   localparam int SUB_HI = 18;
   localparam int SUB_LO = 16;
   localparam int ADR_HI = 15;
   localparam int ADR_LO = 8;
   localparam int DAT_HI = 7;
   localparam int DAT_LO = 0;

   localparam logic [4:0] OPC_VSYNC      = 5'b00010;
   localparam logic [4:0] OPC_PSG        = 5'b10001;
   localparam logic [4:0] OPC_OPLL       = 5'b10010;
   localparam logic [4:0] OPC_SCC        = 5'b10011;
   localparam logic [4:0] OPC_MOVOL      = 5'b11000;
   localparam logic [4:0] OPC_ROVOL      = 5'b11001;
   localparam logic [4:0] OPC_SCC_MODULE = 5'b11010;

   typedef logic [CMD_W-1:0] cmd_t;

   typedef enum logic [1:0] {
      S_ARB    = 2'd0,
      S_TAKE   = 2'd1,
      S_DECODE = 2'd2,
      S_PUSH   = 2'd3
   } arb_state_t;

   function automatic logic [4:0] cmd_opcode(input cmd_t cmd);
      return cmd[OPC_HI:OPC_LO];
   endfunction

   function automatic logic is_vsync(input cmd_t cmd);
      return (cmd_opcode(cmd) == OPC_VSYNC);
   endfunction

endpackage

// File: rtl/mmp_frame_timer.sv
// Free-running 1/60 s frame counter; emits a registered one-cycle tick
// in the cycle after the counter wraps to zero.
module mmp_frame_timer
   import mmp_cmd_pkg::*;
#(
   parameter int unsigned FRAME_TICKS = FRAME_TICKS_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned CNT_W = (FRAME_TICKS > 32'd1) ? $clog2(FRAME_TICKS) : 32'd1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

   logic [CNT_W-1:0] cnt_r;

   // Frame counter with wrap and tick pulse generation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= '0;
         tick  <= 1'b0;
      end else if (cnt_r == CNT_LAST) begin
         cnt_r <= '0;
         tick  <= 1'b1;
      end else begin
         cnt_r <= cnt_r + CNT_ONE;
         tick  <= 1'b0;
      end
   end

endmodule

// File: rtl/mmp_cmd_arbiter.sv
// Round-robin merge of two command producers into the sequencer FIFO, with
// VSYNC commands parking only their issuer until the next frame tick.
module mmp_cmd_arbiter
   import mmp_cmd_pkg::*;
#(
   parameter int unsigned FRAME_TICKS = FRAME_TICKS_DEFAULT
) (
   input  logic              i_CLK,
   input  logic              i_RST_n,
   input  logic              i_req0_valid,
   input  logic [CMD_W-1:0]  i_req0_dt,
   output logic              o_req0_ready,
   input  logic              i_req1_valid,
   input  logic [CMD_W-1:0]  i_req1_dt,
   output logic              o_req1_ready,
   output logic              o_fifo_push_s,
   output logic [CMD_W-1:0]  o_fifo_push_dt,
   input  logic              i_fifo_FULL,
   input  logic              i_frame_en,
   output logic              o_frame_tick,
   output logic [1:0]        o_req_parked
);

   arb_state_t state_r;
   logic       last_r;
   logic       cur_r;
   cmd_t       cap_r;

   logic [1:0] eligible_s;
   logic       grant_s;
   logic       grant_ok_s;
   logic [1:0] park_set_s;
   logic       frame_tick_s;

   mmp_frame_timer #(
      .FRAME_TICKS (FRAME_TICKS)
   ) u_frame_timer (
      .clk   (i_CLK),
      .rst_n (i_RST_n),
      .tick  (frame_tick_s)
   );

   assign o_frame_tick = frame_tick_s;

   // Grant selection: on a tie the requester not granted last time wins.
   always_comb begin
      eligible_s = {i_req1_valid & ~o_req_parked[1], i_req0_valid & ~o_req_parked[0]};
      grant_ok_s = !i_fifo_FULL && (eligible_s != 2'b00);
      if (eligible_s == 2'b11) begin
         grant_s = ~last_r;
      end else if (eligible_s[0]) begin
         grant_s = 1'b0;
      end else begin
         grant_s = 1'b1;
      end
   end

   // Park request raised while a VSYNC sits in decode and pacing is enabled.
   always_comb begin
      if ((state_r == S_DECODE) && i_frame_en && is_vsync(cap_r)) begin
         park_set_s = cur_r ? 2'b10 : 2'b01;
      end else begin
         park_set_s = 2'b00;
      end
   end

   // Arbiter FSM: grant, take, decode, push; one command in flight at a time.
   always_ff @(posedge i_CLK) begin
      if (!i_RST_n) begin
         state_r        <= S_ARB;
         last_r         <= 1'b1;
         cur_r          <= 1'b0;
         cap_r          <= '0;
         o_req0_ready   <= 1'b0;
         o_req1_ready   <= 1'b0;
         o_fifo_push_s  <= 1'b0;
         o_fifo_push_dt <= '0;
      end else begin
         case (state_r)
            S_ARB: begin
               if (grant_ok_s) begin
                  last_r       <= grant_s;
                  cur_r        <= grant_s;
                  o_req0_ready <= ~grant_s;
                  o_req1_ready <= grant_s;
                  state_r      <= S_TAKE;
               end else begin
                  state_r      <= S_ARB;
               end
            end
            S_TAKE: begin
               cap_r        <= cur_r ? i_req1_dt : i_req0_dt;
               o_req0_ready <= 1'b0;
               o_req1_ready <= 1'b0;
               state_r      <= S_DECODE;
            end
            S_DECODE: begin
               // A paced VSYNC is consumed here and never reaches the FIFO.
               if (i_frame_en && is_vsync(cap_r)) begin
                  state_r        <= S_ARB;
               end else begin
                  o_fifo_push_s  <= 1'b1;
                  o_fifo_push_dt <= cap_r;
                  state_r        <= S_PUSH;
               end
            end
            S_PUSH: begin
               o_fifo_push_s <= 1'b0;
               state_r       <= S_ARB;
            end
            default: begin
               o_req0_ready  <= 1'b0;
               o_req1_ready  <= 1'b0;
               o_fifo_push_s <= 1'b0;
               state_r       <= S_ARB;
            end
         endcase
      end
   end

   // Park flags: tick clears, a simultaneous set wins, pacing-off clears all.
   always_ff @(posedge i_CLK) begin
      if (!i_RST_n) begin
         o_req_parked <= 2'b00;
      end else if (!i_frame_en) begin
         o_req_parked <= 2'b00;
      end else begin
         o_req_parked <= (o_req_parked & ~{2{frame_tick_s}}) | park_set_s;
      end
   end

endmodule

// File: doc/mmp_cmd_arbiter.md
# mmp_cmd_arbiter

Two-requester command arbiter with frame pacing, placed in front of the 24-bit command FIFO that feeds the sound-chip sequencer (PSG/OPLL/SCC/WTS writer). It merges command streams from two producers (e.g. host-link receiver and on-chip player) round-robin into the single FIFO. It also restores hardware frame pacing: a VSYNC command (opcode 5'b00010) parks only the issuing requester until the next 1/60 s frame tick, while the other requester keeps flowing.

## Interface
- FRAME_TICKS, 297619, i_CLK cycles per frame (1/60 s); counter wraps at FRAME_TICKS-1.
- i_CLK  in  1  clock.
- i_RST_n  in  1  reset; synchronous, active-low; clock i_CLK.
- i_req0_valid  in  1  requester 0 has a command; must hold with data until o_req0_ready is seen.
- i_req0_dt  in  24  requester 0 command; [23:19] opcode.
- o_req0_ready  out  1  one-cycle accept pulse; transfer on valid&&ready at the clock edge.
- i_req1_valid / i_req1_dt / o_req1_ready: same for requester 1.
- o_fifo_push_s  out  1  one-cycle FIFO write strobe.
- o_fifo_push_dt  out  24  FIFO write data, valid while o_fifo_push_s is high.
- i_fifo_FULL  in  1  FIFO full flag.
- i_frame_en  in  1  1: VSYNC commands park the requester; 0: VSYNC commands are forwarded as ordinary commands.
- o_frame_tick  out  1  one-cycle pulse at each frame counter wrap.
- o_req_parked  out  2  per-requester parked status.

## Operation
- Reset: all outputs 0, parked=2'b00, frame counter 0, last-grant pointer=1 (so requester 0 wins the first tie), state S_ARB, capture register 0.
- Eligible(n) = i_reqn_valid && !parked[n].
- S_ARB: if !i_fifo_FULL and any requester is eligible, grant one. If both are eligible, grant the one not last granted. Update the pointer, register o_reqn_ready<=1, go to S_TAKE. Otherwise stay in S_ARB.
- S_TAKE: ready is high this cycle. Capture i_reqn_dt into the capture register, ready<=0, go to S_DECODE.
- S_DECODE, VSYNC command with i_frame_en=1: parked[g]<=1. The command is consumed and not pushed. Go to S_ARB.
- S_DECODE, any other case: o_fifo_push_s<=1, o_fifo_push_dt<=captured command, go to S_PUSH.
- S_PUSH: o_fifo_push_s<=0, go to S_ARB.
- Frame counter: increments every cycle and wraps from FRAME_TICKS-1 to 0. o_frame_tick is registered high for the cycle after the wrap.
- Parked update: parked_next = (parked & ~{2{tick}}) | set. If a set and a tick coincide, set wins, so the requester waits for the following tick.
- i_frame_en=0: parked is forced to 2'b00 each cycle. The frame counter keeps running.
- Only one command is in flight, and FULL is checked at grant. No push ever occurs into a full FIFO.
- A requester dropping valid while ready is high is a protocol violation. Behaviour in that case is unspecified and is flagged by an assertion in the bench.

## Timing
- Grant decision in cycle t; ready high in t+1; capture at the end of t+1; push strobe high in t+3; back in S_ARB at t+4.
- Throughput: 1 command per 4 cycles. A consumed VSYNC takes 3 cycles.
- Park latency: the requester is parked from t+3 until the first tick after t+2, i.e. at most FRAME_TICKS cycles.
- A parked requester's valid is ignored. The other requester is granted back-to-back every 4 cycles.
- Reset mid-operation: a command captured but not yet pushed is dropped. push_s and ready go low at the next edge.
- FULL asserted while in S_ARB stalls grants indefinitely. Both requesters remain unaccepted.

## Structure
- Shared package mmp_cmd_pkg holds:
  - opcode constants: VSYNC 5'b00010, PSG 10001, OPLL 10010, SCC 10011, MOVOL 11000, ROVOL 11001, SCC_MODULE 11010;
  - command field positions ([23:19] opcode, [18:16] sub-address, [15:8] address, [7:0] data);
  - default FRAME_TICKS.
  The existing sequencer uses the same package.
- Sub-module mmp_frame_timer contains the frame counter and tick pulse, parameterised by FRAME_TICKS. The arbiter FSM and park logic live in mmp_cmd_arbiter.

## Test plan
- Requester 0 only, PSG command 24'h88_07_38 (opcode 10001): o_req0_ready pulses at t+1, and o_fifo_push_dt=24'h880738 with push_s high at t+3.
- Both valid continuously with distinct commands: FIFO receives strict alternation 0,1,0,1 (requester 0 first after reset), one push every 4 cycles.
- FRAME_TICKS=100, i_frame_en=1, requester 0 sends VSYNC 24'h10_00_00 then a PSG command: no push for the VSYNC; parked[0]=1 until the tick; the PSG command is pushed 3 cycles after the tick. Requester 1 traffic continues throughout.
- VSYNC decoded in the same cycle as the tick: the requester stays parked until the next tick, 100 cycles later.
- i_fifo_FULL held high with both requesters valid: no ready and no push. Release FULL: grant in the next S_ARB cycle.
- i_frame_en=0 with VSYNC: 24'h100000 is pushed to the FIFO and parked stays 0. Assert reset between S_TAKE and S_PUSH: no push, all outputs 0.
